bram_d_burst_arbiter: RTL and testbench

- Shares the single asynchronous-read weight ROM (dense-layer vector store, 4-bit words, 64 entries) between two requesters, e.g. the dense-layer MAC and the debug/readback path.
- Each requester asks for a burst of (base, len). The block arbitrates round-robin, walks the ROM address, and streams words out on a valid/ready interface tagged with requester id and last flag.
- It sits between the requesters and the ROM address/data pins.

---
 rtl/bram_d_burst_arbiter.sv | 141 ++++++++++++++
 tb/tb_bram_d_burst_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_d_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_d_burst_arbiter
//  Description : Round-robin burst arbiter in front of an asynchronous-read
//                weight ROM. Two requesters post (base, len) bursts; the
//                winner's words are streamed on a valid/ready port tagged
//                with the owner id and a last-beat flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_d_burst_arbiter #(
    parameter int RAM_WIDTH = 4,
    parameter int ADDR_BITS = 6,
    parameter int LEN_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [ADDR_BITS-1:0] base0,
    input  logic [LEN_BITS-1:0]  len0,
    input  logic                 req1,
    input  logic [ADDR_BITS-1:0] base1,
    input  logic [LEN_BITS-1:0]  len1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [RAM_WIDTH-1:0] rom_data,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_id,
    output logic                 out_last,
    output logic                 done0,
    output logic                 done1,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [LEN_BITS-1:0]  c_len_one  = LEN_BITS'(1);
    localparam logic [ADDR_BITS-1:0] c_addr_one = ADDR_BITS'(1);

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_cur_addr;
    logic [LEN_BITS-1:0]  r_remaining;
    logic                 r_owner;
    logic                 r_last_served;
    logic                 r_zero_len;   // current burst was accepted with len==0
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_done0;
    logic                 r_done1;

    logic                 w_any_req;
    logic                 w_sel;
    logic [ADDR_BITS-1:0] w_base_sel;
    logic [LEN_BITS-1:0]  w_len_sel;
    logic                 w_beat;
    logic                 w_last_beat;

    // Arbitration choice and beat detection; on a tie the requester not served last wins
    always_comb begin
        w_any_req   = req0 | req1;
        w_sel       = (req0 & req1) ? ~r_last_served : req1;
        w_base_sel  = w_sel ? base1 : base0;
        w_len_sel   = w_sel ? len1  : len0;
        w_beat      = (r_state == S_STREAM) & out_ready;
        w_last_beat = w_beat & (r_remaining == c_len_one);
    end

    // Burst FSM: accept in IDLE, walk the ROM in STREAM, pulse completion via DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_zero_len    <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cur_addr  <= w_base_sel;
                        r_remaining <= w_len_sel;
                        r_owner     <= w_sel;
                        r_gnt0      <= ~w_sel;
                        r_gnt1      <= w_sel;
                        r_zero_len  <= (w_len_sel == '0);
                        r_state     <= (w_len_sel == '0) ? S_DONE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_beat) begin
                        // Address wraps naturally modulo the ROM depth
                        r_cur_addr  <= r_cur_addr + c_addr_one;
                        r_remaining <= r_remaining - c_len_one;
                    end
                    if (w_last_beat) begin
                        r_state <= S_DONE;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                    end
                end
                S_DONE: begin
                    r_last_served <= r_owner;
                    r_state       <= S_IDLE;
                    // A zero-length burst has its grant in the DONE cycle, so its
                    // completion pulse lands one cycle later to keep them distinct
                    if (r_zero_len) begin
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr  = r_cur_addr;
    assign out_data  = rom_data;
    assign out_valid = (r_state == S_STREAM);
    assign out_last  = (r_state == S_STREAM) & (r_remaining == c_len_one);
    assign out_id    = r_owner;
    assign busy      = (r_state != S_IDLE);
    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;

endmodule
`default_nettype wire

// File: tb/tb_bram_d_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_d_burst_arbiter
//  Description : Self-checking bench for bram_d_burst_arbiter. A ROM model
//                drives rom_data; expected beats are queued when a burst is
//                requested and popped as the stream delivers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_d_burst_arbiter;

    localparam int DW = 4;
    localparam int AW = 6;
    localparam int LW = 7;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          id;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] base0 = '0, base1 = '0;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic          gnt0, gnt1, out_valid, out_id, out_last, done0, done1, busy;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data, out_data;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb[$];

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return DW'(int'(a) * 7 + 3);
    endfunction

    assign rom_data = rom_f(rom_addr);

    always #5 clk = ~clk;

    bram_d_burst_arbiter #(.RAM_WIDTH(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .base0(base0), .len0(len0),
        .req1(req1), .base1(base1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_last(out_last),
        .done0(done0), .done1(done1), .busy(busy)
    );

    task automatic push_burst(input logic id, input logic [AW-1:0] base, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.addr = base + AW'(i);
            b.id   = id;
            b.last = (i == len - 1);
            sb.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; len0 = 7'd3; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({gnt0, gnt1, done0, done1, out_valid, out_last, out_id, busy} !== 8'h00 ||
            rom_addr !== 6'd0 || out_data !== rom_f(6'd0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got flags=%b addr=%0d data=%0d, want flags=0 addr=0 data=%0d",
                     {gnt0, gnt1, done0, done1, out_valid, out_last, out_id, busy}, rom_addr, out_data, rom_f(6'd0));
        end
        req0 = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        beat_t e;
        int    done_cyc = -1;
        push_burst(1'b0, 6'd5, 4);
        req0 = 1'b1; base0 = 6'd5; len0 = 7'd4; out_ready = 1'b1;
        for (int c = 0; c < 12 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_tests++;
                if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                    n_fail++; $display("FAIL single_gnt: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
                end
                req0 = 1'b0; base0 = 6'd40; len0 = 7'd1;  // must be ignored
            end
            if (out_valid) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL single_spurious: beat at addr %0d, want none", rom_addr);
                end else begin
                    e = sb.pop_front();
                    if (rom_addr !== e.addr || out_data !== rom_f(e.addr) || out_id !== e.id || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL single_beat: got addr=%0d data=%0d id=%b last=%b, want %0d %0d %b %b",
                                 rom_addr, out_data, out_id, out_last, e.addr, rom_f(e.addr), e.id, e.last);
                    end
                end
            end
            if (done0 === 1'b1) done_cyc = c;
        end
        n_tests++;
        if (done_cyc != 4 || sb.size() != 0) begin
            n_fail++; $display("FAIL single_done: got done cycle=%0d left=%0d, want 4 0", done_cyc, sb.size());
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done0 !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got busy=%b done0=%b, want 0 0", busy, done0);
        end
    endtask

    task automatic test_back_pressure();
        beat_t    e;
        int       done_cyc = -1;
        bit [4:0] pat = 5'b11001;  // bit c = ready in cycle c: 1,0,0,1,1
        push_burst(1'b1, 6'd10, 3);
        req1 = 1'b1; base1 = 6'd10; len1 = 7'd3;
        for (int c = 0; c < 14 && done_cyc < 0; c++) begin
            @(negedge clk);
            out_ready = (c < 5) ? pat[c] : 1'b1;
            if (c == 0) begin
                n_tests++;
                if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
                    n_fail++; $display("FAIL bp_gnt: got gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
                end
                req1 = 1'b0;
            end
            if (out_valid) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL bp_spurious: beat at addr %0d, want none", rom_addr);
                end else begin
                    e = sb[0];
                    if (rom_addr !== e.addr || out_data !== rom_f(e.addr) || out_id !== e.id || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL bp_beat: cycle %0d got addr=%0d data=%0d id=%b last=%b, want %0d %0d %b %b",
                                 c, rom_addr, out_data, out_id, out_last, e.addr, rom_f(e.addr), e.id, e.last);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (done1 === 1'b1) done_cyc = c;
        end
        n_tests++;
        if (done_cyc != 5 || sb.size() != 0) begin
            n_fail++; $display("FAIL bp_done: got done cycle=%0d left=%0d, want 5 0", done_cyc, sb.size());
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie_round_robin();
        beat_t e;
        int    g0, g1, d0, d1, need0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        // Round 0: both drop after their grant -> order 0,1.
        // Round 1: req0 stays up after its first grant -> order 0,1,0.
        for (int r = 0; r < 2; r++) begin
            need0 = r + 1;
            push_burst(1'b0, 6'd20, 2);
            push_burst(1'b1, 6'd40, 2);
            if (r == 1) push_burst(1'b0, 6'd20, 2);
            @(negedge clk);
            req0 = 1'b1; base0 = 6'd20; len0 = 7'd2;
            req1 = 1'b1; base1 = 6'd40; len1 = 7'd2;
            g0 = 0; g1 = 0; d0 = 0; d1 = 0;
            for (int c = 0; c < 30 && (d0 < need0 || d1 < 1); c++) begin
                @(negedge clk);
                if (gnt0 === 1'b1) begin g0++; if (g0 >= need0) req0 = 1'b0; end
                if (gnt1 === 1'b1) begin g1++; req1 = 1'b0; end
                if (done0 === 1'b1) d0++;
                if (done1 === 1'b1) d1++;
                if (out_valid) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL tie_spurious: round %0d beat at addr %0d, want none", r, rom_addr);
                    end else begin
                        e = sb.pop_front();
                        if (rom_addr !== e.addr || out_data !== rom_f(e.addr) || out_id !== e.id || out_last !== e.last) begin
                            n_fail++;
                            $display("FAIL tie_beat: round %0d got addr=%0d id=%b last=%b, want %0d %b %b",
                                     r, rom_addr, out_id, out_last, e.addr, e.id, e.last);
                        end
                    end
                end
            end
            n_tests++;
            if (g0 != need0 || g1 != 1 || d0 != need0 || d1 != 1 || sb.size() != 0) begin
                n_fail++;
                $display("FAIL tie_counts: round %0d got g0=%0d g1=%0d d0=%0d d1=%0d left=%0d, want %0d 1 %0d 1 0",
                         r, g0, g1, d0, d1, sb.size(), need0, need0);
            end
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        beat_t         e;
        int            done_cyc;
        logic [AW-1:0] bases [2] = '{6'd62, 6'd60};
        int            lens  [2] = '{4, 66};
        for (int k = 0; k < 2; k++) begin
            push_burst(1'b0, bases[k], lens[k]);
            req0 = 1'b1; base0 = bases[k]; len0 = LW'(lens[k]); out_ready = 1'b1;
            done_cyc = -1;
            for (int c = 0; c < lens[k] + 8 && done_cyc < 0; c++) begin
                @(negedge clk);
                if (c == 0) req0 = 1'b0;
                if (out_valid) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL wrap_spurious: burst %0d beat at addr %0d, want none", k, rom_addr);
                    end else begin
                        e = sb.pop_front();
                        if (rom_addr !== e.addr || out_data !== rom_f(e.addr) || out_id !== e.id || out_last !== e.last) begin
                            n_fail++;
                            $display("FAIL wrap_beat: burst %0d got addr=%0d data=%0d last=%b, want %0d %0d %b",
                                     k, rom_addr, out_data, out_last, e.addr, rom_f(e.addr), e.last);
                        end
                    end
                end
                if (done0 === 1'b1) done_cyc = c;
            end
            n_tests++;
            if (done_cyc != lens[k] || sb.size() != 0) begin
                n_fail++;
                $display("FAIL wrap_done: burst %0d got done cycle=%0d left=%0d, want %0d 0", k, done_cyc, sb.size(), lens[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_length();
        logic [3:0] seen [3];
        req1 = 1'b1; base1 = 6'd17; len1 = 7'd0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) req1 = 1'b0;
            seen[c] = {gnt1, done1, out_valid, gnt0 | done0};
        end
        n_tests++;
        if (seen[0] !== 4'b1000 || seen[1] !== 4'b0100 || seen[2] !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_len: got {gnt1,done1,valid,other} = %b %b %b, want 1000 0100 0000",
                     seen[0], seen[1], seen[2]);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_len_busy: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        beat_t e;
        int    bad_done, done_cyc;
        push_burst(1'b0, 6'd0, 8);
        req0 = 1'b1; base0 = 6'd0; len0 = 7'd8; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) req0 = 1'b0;
            n_tests++;
            e = sb.pop_front();
            if (out_valid !== 1'b1 || rom_addr !== e.addr || out_data !== rom_f(e.addr) || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_beat: got valid=%b addr=%0d last=%b, want 1 %0d 0", out_valid, rom_addr, out_last, e.addr);
            end
        end
        sb.delete();
        @(negedge clk);
        out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || rom_addr !== 6'd0 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got valid=%b busy=%b done0=%b addr=%0d, want 0 0 0 0",
                     out_valid, busy, done0, rom_addr);
        end
        bad_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 === 1'b1 || out_valid === 1'b1) bad_done++;
        end
        n_tests++;
        if (bad_done != 0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles after reset, want 0", bad_done);
        end
        push_burst(1'b1, 6'd33, 3);
        req1 = 1'b1; base1 = 6'd33; len1 = 7'd3;
        done_cyc = -1;
        for (int c = 0; c < 10 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) req1 = 1'b0;
            if (out_valid) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rst_after_spurious: beat at addr %0d, want none", rom_addr);
                end else begin
                    e = sb.pop_front();
                    if (rom_addr !== e.addr || out_data !== rom_f(e.addr) || out_id !== e.id || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL rst_after_beat: got addr=%0d id=%b last=%b, want %0d %b %b",
                                 rom_addr, out_id, out_last, e.addr, e.id, e.last);
                    end
                end
            end
            if (done1 === 1'b1) done_cyc = c;
        end
        n_tests++;
        if (done_cyc != 3 || sb.size() != 0) begin
            n_fail++; $display("FAIL rst_after_done: got done cycle=%0d left=%0d, want 3 0", done_cyc, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_pressure();
        test_tie_round_robin();
        test_wrap();
        test_zero_length();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
